// File: rtl/color_shuffler_if.sv
// color_shuffler_if: round request/handshake and registered colour results
interface color_shuffler_if #(
  parameter int NUM_PLATS = 4,
  parameter int COLOR_W = 3
);
  localparam int IW = NUM_PLATS > 1 ? $clog2(NUM_PLATS) : 1;
  logic req;
  logic busy;
  logic done;
  logic [COLOR_W-1:0] ball_color;
  logic [NUM_PLATS*COLOR_W-1:0] plat_colors;
  logic [IW-1:0] match_idx;
  modport master (output req, input busy, done, ball_color, plat_colors, match_idx);
  modport slave (input req, output busy, done, ball_color, plat_colors, match_idx);
endinterface

// File: rtl/color_shuffler.sv
// color_shuffler: picks ball colour, target slot and platform colours; COLOR_SHUFFLER_DISTINCT_EN makes all slots distinct
module color_shuffler #(
  parameter int NUM_PLATS = 4,
  parameter int COLOR_W = 3,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input logic clk,
  input logic resetn,
  color_shuffler_if.slave bus
);
  localparam int IW = NUM_PLATS > 1 ? $clog2(NUM_PLATS) : 1;
  localparam logic [15:0] SEED_EFF = SEED == 16'd0 ? 16'hACE1 : SEED;
  localparam logic [IW:0] NP = (IW+1)'(NUM_PLATS);
  localparam logic [IW-1:0] LAST = IW'(NUM_PLATS - 1);
`ifdef COLOR_SHUFFLER_DISTINCT_EN
  if (NUM_PLATS > 2**COLOR_W - 1) begin : g_too_many_plats
    $error("distinct mode needs NUM_PLATS <= 2**COLOR_W - 1");
  end
`endif
  typedef enum logic [2:0] {IDLE, BALL, POS, FILL, DONE} state_t;
  state_t state, state_nx;
  logic [15:0] lfsr;
  logic [COLOR_W-1:0] cand, probe, ball, commit_val;
  logic first, at_target, plat_ok, dup, commit, last;
  logic [IW-1:0] idx, target, pos;
  logic [IW:0] pos_ext;
  logic [NUM_PLATS*COLOR_W-1:0] stage, stage_nx;
  always_comb begin
    probe = first ? lfsr[COLOR_W-1:0] : cand + 1'b1;
    at_target = idx == target;
    last = idx == LAST;
    dup = 1'b0;
`ifdef COLOR_SHUFFLER_DISTINCT_EN
    for (int j = 0; j < NUM_PLATS; j++)
      if (j < int'(idx) && stage[j*COLOR_W +: COLOR_W] == probe) dup = 1'b1;
`endif
    plat_ok = probe != '0 && probe != ball && !dup;
    commit = state == BALL ? probe != '0 : state == FILL && (at_target || plat_ok);
    commit_val = at_target ? ball : probe;
    stage_nx = stage;
    if (state == FILL && commit) stage_nx[idx*COLOR_W +: COLOR_W] = commit_val;
    pos_ext = {1'b0, lfsr[IW-1:0]};
    pos = pos_ext >= NP ? IW'(pos_ext - NP) : lfsr[IW-1:0];
  end
  always_comb begin
    state_nx = state;
    bus.busy = state == BALL || state == POS || state == FILL;
    bus.done = state == DONE;
    case (state)
      IDLE: state_nx = bus.req ? BALL : IDLE;
      BALL: state_nx = commit ? POS : BALL;
      POS: state_nx = FILL;
      FILL: state_nx = commit && last ? DONE : FILL;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= !resetn ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lfsr <= SEED_EFF;
      cand <= '0;
      first <= 1'b1;
      ball <= '0;
      idx <= '0;
      target <= '0;
      stage <= '0;
      bus.ball_color <= '0;
      bus.plat_colors <= '0;
      bus.match_idx <= '0;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      if (state == BALL || (state == FILL && !at_target)) begin
        cand <= probe;
        first <= commit;
      end
      if (state == BALL && commit) ball <= probe;
      if (state == POS) begin
        target <= pos;
        idx <= '0;
      end
      if (state == FILL && commit) begin
        stage <= stage_nx;
        idx <= idx + 1'b1;
      end
      if (state == FILL && commit && last) begin
        bus.ball_color <= ball;
        bus.plat_colors <= stage_nx;
        bus.match_idx <= target;
      end
    end
  end
endmodule
